// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared FSM state type and offset-binary to two's-complement conversion
// for the FIFO frame reader.
package fifo_rd_pkg;
  typedef enum logic {IDLE, STREAM} state_t;
  // Flip the MSB of the low `bits` bits, then sign-extend from that bit.
  // Wide fixed width so callers can truncate to any data width.
  function automatic logic [63:0] offset_to_signed(input logic [63:0] code, input int bits);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (64'd1 << bits) - 64'd1;
    v = (code ^ (64'd1 << (bits - 1))) & mask;
    return v[bits-1] ? (v | ~mask) : v;
  endfunction
endpackage

// File: rtl/fifo_frame_reader_if.sv
// fifo_frame_reader_if: FIFO read port plus valid/ready stream towards the FFT.
//   master: the reader (drives fifo_rd_en, m_data, m_valid, m_last)
//   slave : FIFO + FFT side (drives fifo_rd_data, fifo_empty, fifo_level, m_ready)
interface fifo_frame_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEVEL_W    = 14
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic [LEVEL_W-1:0]    fifo_level;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  modport master (
    output fifo_rd_en, m_data, m_valid, m_last,
    input  fifo_rd_data, fifo_empty, fifo_level, m_ready
  );
  modport slave (
    input  fifo_rd_en, m_data, m_valid, m_last,
    output fifo_rd_data, fifo_empty, fifo_level, m_ready
  );
endinterface

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order valid/ready buffer.
//   rd_clk/rd_rst_n : clock, sync active-low reset
//   wr/din          : unconditional write (caller guarantees space)
//   ready           : downstream accepts head when valid
//   dout/valid      : head entry
//   occ             : entries held (0..2)
module fifo_rd_skid #(
  parameter int W = 17
) (
  input  logic         rd_clk,
  input  logic         rd_rst_n,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   occ
);
  logic [W-1:0] d1;
  logic         pop;
  logic [1:0]   base;
  assign valid = occ != 2'd0;
  assign pop   = valid && ready;
  // slot the incoming word lands in after this cycle's pop shifts the queue
  assign base  = occ - 2'(pop);
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      occ  <= 2'd0;
      dout <= '0;
      d1   <= '0;
    end else begin
      occ <= base + 2'(wr);
      if (wr && base == 2'd0) dout <= din;
      else if (pop) dout <= d1;
      if (wr && base == 2'd1) d1 <= din;
    end
  end
endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains one FRAME_LEN frame at a time from the async FIFO into the FFT.
//   rd_clk/rd_rst_n : FFT-domain clock, sync active-low reset
//   start_en        : frames may start while high
//   bus (master)    : FIFO read port and valid/ready/last stream
//   frame_done      : pulse on acceptance of the last beat
//   underrun        : sticky, FIFO ran empty while words were still owed
module fifo_frame_reader import fifo_rd_pkg::*; #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADC_BITS    = 10,
  parameter int LEVEL_W     = 14,
  parameter int FRAME_LEN   = 1024,
  parameter int SIGNED_CONV = 1
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic                 start_en,
  fifo_frame_reader_if.master  bus,
  output logic                 frame_done,
  output logic                 underrun
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LEN  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  state_t                state;
  logic                  level_ok, inflight, last_pend, pop, rd_en, end_beat, head_valid;
  logic [CW-1:0]         issued, accepted;
  logic [1:0]            occ;
  logic [DATA_WIDTH:0]   head;
  logic [DATA_WIDTH-1:0] conv;
  assign pop = bus.m_valid && bus.m_ready;
  // Space is judged after this cycle's pop so a word can be issued every cycle
  // while the head drains; the skid never needs more than two slots.
  assign rd_en = state == STREAM && !bus.fifo_empty && issued < LEN &&
                 (occ - 2'(pop) + 2'(inflight)) < 2'd2;
  assign end_beat       = pop && accepted == LAST;
  assign frame_done     = end_beat;
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = head_valid;
  assign bus.m_data     = head[DATA_WIDTH-1:0];
  assign bus.m_last     = head_valid && head[DATA_WIDTH];
  assign conv = SIGNED_CONV != 0 ? DATA_WIDTH'(offset_to_signed(64'(bus.fifo_rd_data), ADC_BITS))
                                 : bus.fifo_rd_data;
  // read data returns one cycle after rd_en; inflight marks it and last_pend tags the final word
  fifo_rd_skid #(.W(DATA_WIDTH + 1)) u_skid (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .wr       (inflight),
    .din      ({last_pend, conv}),
    .ready    (bus.m_ready),
    .dout     (head),
    .valid    (head_valid),
    .occ      (occ)
  );
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state     <= IDLE;
      level_ok  <= 1'b0;
      inflight  <= 1'b0;
      last_pend <= 1'b0;
      issued    <= '0;
      accepted  <= '0;
      underrun  <= 1'b0;
    end else begin
      level_ok  <= state == IDLE && start_en && bus.fifo_level >= LEVEL_W'(FRAME_LEN);
      inflight  <= rd_en;
      last_pend <= rd_en && issued == LAST;
      if (state == IDLE) begin
        if (level_ok) state <= STREAM;
      end else begin
        issued   <= end_beat ? '0 : issued + CW'(rd_en);
        accepted <= end_beat ? '0 : accepted + CW'(pop);
        if (bus.fifo_empty && issued < LEN) underrun <= 1'b1;
        if (end_beat) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: directed frames against a FIFO model with a scoreboard of converted samples.
module tb_fifo_frame_reader;
  localparam int DW = 16, LW = 14, FL = 16;
  logic clk = 1'b0, rst_n = 1'b0, start_en = 1'b0;
  logic frame_done, underrun;
  fifo_frame_reader_if #(.DATA_WIDTH(DW), .LEVEL_W(LW)) bus();
  fifo_frame_reader #(
    .DATA_WIDTH(DW), .ADC_BITS(10), .LEVEL_W(LW), .FRAME_LEN(FL), .SIGNED_CONV(1)
  ) dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .start_en(start_en), .bus(bus),
    .frame_done(frame_done), .underrun(underrun)
  );
  always #5 clk = ~clk;
  logic [15:0] fq[$];
  logic [15:0] exp_q[$];
  int wr_cnt = 0, rd_cnt_f = 0, vectors = 0, errors = 0, beat = 0, frames = 0;
  int rd_cnt = 0, done_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  logic force_empty = 1'b0, rnd = 1'b0, stall = 1'b0, held_last = 1'b0;
  logic [15:0] held = '0;
  assign bus.fifo_empty = (wr_cnt == rd_cnt_f) || force_empty;
  assign bus.fifo_level = LW'(wr_cnt - rd_cnt_f);
  always @(posedge clk)
    if (bus.fifo_rd_en && fq.size() > 0) begin
      bus.fifo_rd_data <= fq.pop_front();
      rd_cnt_f <= rd_cnt_f + 1;
    end
  function automatic logic [15:0] conv10(input logic [15:0] w);
    logic [9:0] x;
    x = w[9:0] ^ 10'h200;
    return {{6{x[9]}}, x};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [15:0] w, input logic [15:0] e);
    fq.push_back(w);
    exp_q.push_back(e);
    wr_cnt++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_frames(input int n);
    for (int i = 0; i < 500 && frames < n; i++) @(negedge clk);
    check("frame_count", frames, n);
  endtask
  task automatic wait_beat(input int b);
    for (int i = 0; i < 200 && beat < b; i++) @(negedge clk);
    check("beat_reach", 32'(beat >= b), 1);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_data", bus.m_data, held);
        check("hold_last", bus.m_last, held_last);
      end
      if (bus.fifo_empty) check("rd_on_empty", bus.fifo_rd_en, 0);
      if (bus.fifo_rd_en) rd_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("data", bus.m_data, exp_q.pop_front());
        check("last", bus.m_last, beat == FL - 1);
        check("done", frame_done, beat == FL - 1);
        if (beat == 0) first_cyc = cyc;
        if (beat == FL - 1) begin
          last_cyc = cyc;
          frames++;
          beat = 0;
        end else beat++;
      end
      stall = bus.m_valid && !bus.m_ready;
      held = bus.m_data;
      held_last = bus.m_last;
    end else stall = 1'b0;
    if (frame_done) done_cnt++;
    cyc++;
  end
  initial begin
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_valid", bus.m_valid, 0);
    check("rst_last", bus.m_last, 0);
    check("rst_data", bus.m_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    step();
    rst_n = 1'b1;
    // full frame, m_ready held high
    for (int i = 0; i < FL; i++) push(16'(i), conv10(16'(i)));
    bus.m_ready = 1'b1;
    start_en = 1'b1;
    rd_cnt = 0;
    wait_frames(1);
    check("t1_no_gaps", last_cyc - first_cyc, FL - 1);
    check("t1_rd_en_cnt", rd_cnt, FL);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_underrun", underrun, 0);
    check("t1_drained", exp_q.size(), 0);
    // random backpressure
    step();
    rd_cnt = 0;
    rnd = 1'b1;
    for (int i = 0; i < FL; i++) push(16'h100 + 16'(i), conv10(16'h100 + 16'(i)));
    wait_frames(2);
    step();
    rnd = 1'b0;
    bus.m_ready = 1'b1;
    check("t2_rd_en_cnt", rd_cnt, FL);
    check("t2_done_cnt", done_cnt, 2);
    check("t2_drained", exp_q.size(), 0);
    // one word short of a frame, then complete it
    rd_cnt = 0;
    for (int i = 0; i < FL - 1; i++) push(16'h050 + 16'(i), conv10(16'h050 + 16'(i)));
    repeat (20) @(negedge clk);
    check("t3_no_rd_en", rd_cnt, 0);
    check("t3_idle_valid", bus.m_valid, 0);
    step();
    push(16'h05F, conv10(16'h05F));
    wait_frames(3);
    check("t3_rd_en_cnt", rd_cnt, FL);
    // conversion corner codes
    step();
    push(16'h000, 16'hFE00);
    push(16'h200, 16'h0000);
    push(16'h3FF, 16'h01FF);
    for (int i = 3; i < FL; i++) push(16'(i * 37), conv10(16'(i * 37)));
    wait_frames(4);
    check("t4_drained", exp_q.size(), 0);
    // FIFO looks empty for 3 cycles mid-frame
    step();
    for (int i = 0; i < FL; i++) push(16'h2A0 + 16'(i), conv10(16'h2A0 + 16'(i)));
    wait_beat(5);
    step();
    force_empty = 1'b1;
    repeat (3) step();
    force_empty = 1'b0;
    @(negedge clk);
    check("t5_underrun", underrun, 1);
    wait_frames(5);
    check("t5_drained", exp_q.size(), 0);
    check("t5_underrun_sticky", underrun, 1);
    // reset at beat 7, then a fresh frame after the FIFO is flushed
    step();
    for (int i = 0; i < FL; i++) push(16'h3C0 + 16'(i), conv10(16'h3C0 + 16'(i)));
    wait_beat(7);
    step();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rd_en", bus.fifo_rd_en, 0);
    check("t6_valid", bus.m_valid, 0);
    check("t6_last", bus.m_last, 0);
    check("t6_data", bus.m_data, 0);
    check("t6_done", frame_done, 0);
    check("t6_underrun", underrun, 0);
    fq.delete();
    exp_q.delete();
    wr_cnt = rd_cnt_f;
    beat = 0;
    step();
    rst_n = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < FL; i++) push(16'h011 + 16'(i), conv10(16'h011 + 16'(i)));
    wait_frames(6);
    check("t6_rd_en_cnt", rd_cnt, FL);
    check("t6_underrun_after", underrun, 0);
    check("t6_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
